// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - instruction prefetch unit with in-order queue and redirect flush
// Optional FETCH_PERF_COUNTERS_EN adds delivered/redirect counters.
module prefetch_fetch_unit #(
    parameter int unsigned           DATA_BITS   = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [DATA_BITS-1:0]  RESET_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [DATA_BITS-1:0] redirect_pc,
    output logic                 imem_rd_en,
    output logic [DATA_BITS-1:0] imem_addr,
    input  logic [DATA_BITS-1:0] imem_rdata,
    output logic                 inst_valid,
    output logic [DATA_BITS-1:0] inst_data,
    output logic [DATA_BITS-1:0] inst_pc,
    input  logic                 inst_ready,
    output logic [31:0]          fetch_count,
    output logic [31:0]          flush_count
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(QUEUE_DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] pc_q, pc_d;
    logic [DATA_BITS-1:0] req_pc_q, req_pc_d;
    logic                 pend_q, pend_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] last_data_q, last_data_d, last_pc_q, last_pc_d;
    logic [DATA_BITS-1:0] q_data [QUEUE_DEPTH];
    logic [DATA_BITS-1:0] q_pc   [QUEUE_DEPTH];
    logic                 empty, pop, push, issue;
    logic [CNT_W:0]       credit;

    always_comb begin
        empty  = (count_q == '0);
        pop    = !empty && inst_ready;
        push   = pend_q && !redirect_valid;
        // A slot freed by this cycle's pop is reusable: the new response lands a cycle later.
        credit = {1'b0, count_q} + (CNT_W + 1)'(pend_q) - (CNT_W + 1)'(pop);
        issue  = (state_q == ST_RUN) && !redirect_valid && (credit < DEPTH_L);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc & ~DATA_BITS'(3);
        else if (issue)
            pc_d = pc_q + DATA_BITS'(4);

        req_pc_d = issue ? pc_q : req_pc_q;
        pend_d   = issue;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        last_data_d = empty ? last_data_q : q_data[rd_ptr_q];
        last_pc_d   = empty ? last_pc_q   : q_pc[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            pend_q      <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            last_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            pend_q      <= pend_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            last_data_q <= last_data_d;
            last_pc_q   <= last_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr_q] <= imem_rdata;
            q_pc[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = pc_q;
    assign inst_valid = !empty;
    assign inst_data  = empty ? last_data_q : q_data[rd_ptr_q];
    assign inst_pc    = empty ? last_pc_q   : q_pc[rd_ptr_q];

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        flush_cnt_d = flush_cnt_q + 32'(redirect_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb/tb_prefetch_fetch_unit.sv - directed self-checking bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;
    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_PERF_COUNTERS_EN
    localparam logic [31:0] EXP_FETCH10 = 32'd10;
    localparam logic [31:0] EXP_FLUSH3  = 32'd3;
`else
    localparam logic [31:0] EXP_FETCH10 = 32'd0;
    localparam logic [31:0] EXP_FLUSH3  = 32'd0;
`endif

    prefetch_fetch_unit #(
        .DATA_BITS   (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns word index (addr/4) one cycle after the request.
    initial imem_rdata = '0;
    always @(posedge clk) if (imem_rd_en) imem_rdata <= imem_addr >> 2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
        chk({tag, "_addr"},  imem_addr,   32'h0);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_data"},  inst_data,   32'h0);
        chk({tag, "_pc"},    inst_pc,     32'h0);
        chk({tag, "_fcnt"},  fetch_count, 32'h0);
        chk({tag, "_flcnt"}, flush_count, 32'h0);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #2;
        chk_reset("rst0");
        step(); step();
        rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
        #1;
        chk("idle_no_req", {31'd0, imem_rd_en}, 32'd0);
        step(); #1;
        chk("first_req", {31'd0, imem_rd_en}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        step(); #1;
        chk("second_addr", imem_addr, 32'h4);
        chk("lat_not_valid", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            chk("stream_valid", {31'd0, inst_valid}, 32'd1);
            chk("stream_pc", inst_pc, 32'(4 * k));
            chk("stream_data", inst_data, 32'(k));
        end

        // Redirect with a request in flight; head handshake in the same cycle.
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("fcnt_10", fetch_count, EXP_FETCH10);
        chk("redir_no_req", {31'd0, imem_rd_en}, 32'd0);
        chk("redir_head_pc", inst_pc, 32'd40);
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        #1;
        chk("redir_n1_req", {31'd0, imem_rd_en}, 32'd1);
        chk("redir_n1_addr", imem_addr, 32'h100);
        chk("redir_n1_empty", {31'd0, inst_valid}, 32'd0);
        step(); #1;
        chk("redir_n2_addr", imem_addr, 32'h104);
        chk("stale_dropped", {31'd0, inst_valid}, 32'd0);
        step(); #1;
        chk("redir_n3_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_n3_pc", inst_pc, 32'h100);
        chk("redir_n3_data", inst_data, 32'h40);
        chk("fill_addr3", imem_addr, 32'h108);
        step(); #1;
        chk("fill_req4", {31'd0, imem_rd_en}, 32'd1);
        chk("fill_addr4", imem_addr, 32'h10c);
        step(); #1;
        chk("full_stop", {31'd0, imem_rd_en}, 32'd0);
        step(); #1;
        chk("full_hold", {31'd0, imem_rd_en}, 32'd0);
        chk("full_head", inst_pc, 32'h100);
        step();
        inst_ready = 1'b1;
        #1;
        chk("resume_pc", inst_pc, 32'h100);
        chk("resume_data", inst_data, 32'h40);
        chk("resume_req", {31'd0, imem_rd_en}, 32'd1);
        chk("resume_addr", imem_addr, 32'h110);
        for (int j = 1; j <= 4; j++) begin
            step(); #1;
            chk("drain_pc", inst_pc, 32'(32'h100 + 4 * j));
            chk("drain_data", inst_data, 32'(32'h40 + j));
        end

        // Back-to-back redirects with unaligned targets; the last one wins.
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h303;
        #1;
        chk("b2b_no_req1", {31'd0, imem_rd_en}, 32'd0);
        step();
        redirect_pc = 32'h203;
        #1;
        chk("b2b_no_req2", {31'd0, imem_rd_en}, 32'd0);
        chk("b2b_flushed", {31'd0, inst_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("align_req", {31'd0, imem_rd_en}, 32'd1);
        chk("align_addr", imem_addr, 32'h200);
        step(); #1;
        chk("align_empty", {31'd0, inst_valid}, 32'd0);
        step();
        inst_ready = 1'b0;
        #1;
        chk("align_valid", {31'd0, inst_valid}, 32'd1);
        chk("align_pc", inst_pc, 32'h200);
        chk("align_data", inst_data, 32'h80);
        chk("flcnt_3", flush_count, EXP_FLUSH3);

        // Fill the queue, then pulse reset mid-stream.
        step(); step(); step(); #1;
        chk("full2_stop", {31'd0, imem_rd_en}, 32'd0);
        chk("full2_valid", {31'd0, inst_valid}, 32'd1);
        chk("full2_head", inst_pc, 32'h200);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        step(); step();
        rst = 1'b0; inst_ready = 1'b1;
        #1;
        chk("rst2_idle", {31'd0, imem_rd_en}, 32'd0);
        step(); #1;
        chk("rst2_req", {31'd0, imem_rd_en}, 32'd1);
        chk("rst2_addr", imem_addr, 32'h0);
        step(); #1;
        chk("rst2_empty", {31'd0, inst_valid}, 32'd0);
        step();
        fetch_en = 1'b0;
        #1;
        chk("rst2_valid", {31'd0, inst_valid}, 32'd1);
        chk("rst2_pc", inst_pc, 32'h0);
        chk("rst2_data", inst_data, 32'h0);
        step(); #1;
        chk("idle_stop", {31'd0, imem_rd_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
